hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: CNT_W, default 16, width of the performance counters.
REQ-002 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_i  in  1  reset; asynchronous, active-low.
REQ-004 IFID_Rs1_i, IFID_Rs2_i  in  5 each  source register fields of the instruction in ID.
REQ-005 IFID_UsesRs1_i, IFID_UsesRs2_i  in  1 each  instruction in ID reads rs1 / rs2.
REQ-006 IFID_Branch_i  in  1  instruction in ID is a branch resolved in ID.
REQ-007 BranchTaken_i  in  1  branch comparison in ID evaluates taken; meaningful only when IFID_Branch_i is high.
REQ-008 IDEX_RegWrite_i, IDEX_MemRead_i  in  1 each  control bits currently held in the ID/EX register.
REQ-009 IDEX_Rd_i  in  5  destination register field of the instruction in EX.
REQ-010 EXMEM_MemRead_i  in  1  instruction in MEM is a load.
REQ-011 EXMEM_Rd_i  in  5  destination register field of the instruction in MEM.
REQ-012 PCWrite_o  out  1  PC update enable.
REQ-013 IFIDWrite_o  out  1  IF/ID register update enable.
REQ-014 Bubble_o  out  1  forces all ID/EX control inputs (RegWrite, MemtoReg, MemRead, MemWrite, ALUOp, ALUSrc) to zero.
REQ-015 IFIDFlush_o  out  1  replaces the IF/ID instruction with a NOP.
REQ-016 StallCnt_o, FlushCnt_o  out  CNT_W each  saturating counts of stall cycles and flushes.
REQ-017 StallErr_o  out  1  sticky flag, set when the stall-depth rule is violated.

Function
REQ-018 Match rule: X matches Rd when Rd != 0 and ((UsesRs1 and Rs1 == Rd) or (UsesRs2 and Rs2 == Rd)).
REQ-019 A load-use hazard (LU) exists when IDEX_MemRead_i is high and the ID sources match IDEX_Rd_i.
REQ-020 A branch-ALU hazard (BA) exists when IFID_Branch_i and IDEX_RegWrite_i are high and the ID sources match IDEX_Rd_i.
REQ-021 A branch-load hazard (BL) exists when IFID_Branch_i and EXMEM_MemRead_i are high and the ID sources match EXMEM_Rd_i.
REQ-022 stall = LU or BA or BL; the decision is combinational, same cycle.
REQ-023 When stall is high: PCWrite_o = 0, IFIDWrite_o = 0, Bubble_o = 1, IFIDFlush_o = 0.
REQ-024 When stall is low: PCWrite_o = 1, IFIDWrite_o = 1, Bubble_o = 0, IFIDFlush_o = IFID_Branch_i and BranchTaken_i.
REQ-025 Stall has priority over flush; a taken branch whose operands are not ready SHALL NOT flush.
REQ-026 FSM states RUN, STALL1, STALL2, registered.
REQ-027 FSM transitions: RUN->STALL1 on stall; STALL1->STALL2 on stall; STALL1->RUN on no stall; STALL2->RUN on no stall.
REQ-028 STALL2 with stall still high SHALL set StallErr_o and hold STALL2; maximum legal stall depth is 2 (load in EX feeding a branch).
REQ-029 StallCnt_o SHALL increment by 1 on every clock edge where stall is high, saturating at all-ones.
REQ-030 FlushCnt_o SHALL increment by 1 on every clock edge where IFIDFlush_o is high, saturating at all-ones.
REQ-031 Register 0 never causes a hazard, regardless of the control bits.

Reset
REQ-032 While rst_i is low: state = RUN, StallCnt_o = 0, FlushCnt_o = 0, StallErr_o = 0, PCWrite_o = 0, IFIDWrite_o = 0, Bubble_o = 1, IFIDFlush_o = 0.
REQ-033 Reset asserted mid-stall SHALL return the block to RUN immediately, without waiting for a clock edge.

Structure
REQ-034 FSM state encoding and the NOP instruction constant belong in a shared pipeline package.
REQ-035 One sub-module, reg_match, SHALL implement REQ-018 and SHALL be instantiated three times.

Verification
REQ-036 Scenario 1: lw x5 in EX (IDEX_MemRead=1, Rd=5), add x6,x5,x1 in ID -> exactly 1 cycle with PCWrite=0 and Bubble=1; StallCnt goes 0->1.
REQ-037 Scenario 2: lw x5 in EX, beq x5,x0 in ID -> 2 stall cycles, FSM RUN->STALL1->STALL2->RUN, no StallErr.
REQ-038 Scenario 3: taken beq with no hazard -> IFIDFlush=1 for 1 cycle; FlushCnt 0->1.
REQ-039 Scenario 4: taken branch with BA hazard -> stall 1 cycle with no flush, then flush on the next cycle.
REQ-040 Scenario 5: IDEX_MemRead=1, Rd=0, Rs1=0 -> no stall.
REQ-041 Scenario 6: rst_i driven low during STALL2 -> all outputs at reset values; with CNT_W=2 and 5 stalls the counter holds at 3.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard unit.
// FSM encoding, NOP word and register-field width.
package hazard_ctrl_pkg;

  localparam int REG_W = 5;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL1 = 2'd1,
    STALL2 = 2'd2
  } state_e;

endpackage

// File: rtl/hazard_ctrl_reg_match.sv
// Source/destination register comparator.
// x0 is hardwired zero, so it never matches.
module reg_match
  import hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic             usesRs1,
  input  logic             usesRs2,
  input  logic [REG_W-1:0] rd,
  output logic             hit
);

  logic rdLive;
  logic hit1;
  logic hit2;

  assign rdLive = (rd != '0);
  assign hit1   = usesRs1 && (rs1 == rd);
  assign hit2   = usesRs2 && (rs2 == rd);
  assign hit    = rdLive && (hit1 || hit2);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard detection for a branch-in-ID pipeline.
// Stalls on load-use / branch operand hazards, flushes taken branches.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [REG_W-1:0] IFID_Rs1_i,
  input  logic [REG_W-1:0] IFID_Rs2_i,
  input  logic             IFID_UsesRs1_i,
  input  logic             IFID_UsesRs2_i,
  input  logic             IFID_Branch_i,
  input  logic             BranchTaken_i,
  input  logic             IDEX_RegWrite_i,
  input  logic             IDEX_MemRead_i,
  input  logic [REG_W-1:0] IDEX_Rd_i,
  input  logic             EXMEM_MemRead_i,
  input  logic [REG_W-1:0] EXMEM_Rd_i,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             Bubble_o,
  output logic             IFIDFlush_o,
  output logic [CNT_W-1:0] StallCnt_o,
  output logic [CNT_W-1:0] FlushCnt_o,
  output logic             StallErr_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e state;

  logic luMatch;
  logic baMatch;
  logic blMatch;
  logic luHaz;
  logic baHaz;
  logic blHaz;
  logic stall;
  logic stallLive;
  logic takenBr;

  reg_match uLuMatch (
    .rs1     (IFID_Rs1_i),
    .rs2     (IFID_Rs2_i),
    .usesRs1 (IFID_UsesRs1_i),
    .usesRs2 (IFID_UsesRs2_i),
    .rd      (IDEX_Rd_i),
    .hit     (luMatch)
  );

  reg_match uBaMatch (
    .rs1     (IFID_Rs1_i),
    .rs2     (IFID_Rs2_i),
    .usesRs1 (IFID_UsesRs1_i),
    .usesRs2 (IFID_UsesRs2_i),
    .rd      (IDEX_Rd_i),
    .hit     (baMatch)
  );

  reg_match uBlMatch (
    .rs1     (IFID_Rs1_i),
    .rs2     (IFID_Rs2_i),
    .usesRs1 (IFID_UsesRs1_i),
    .usesRs2 (IFID_UsesRs2_i),
    .rd      (EXMEM_Rd_i),
    .hit     (blMatch)
  );

  assign luHaz = IDEX_MemRead_i && luMatch;
  assign baHaz = IFID_Branch_i && IDEX_RegWrite_i && baMatch;
  assign blHaz = IFID_Branch_i && EXMEM_MemRead_i && blMatch;
  assign stall = luHaz || baHaz || blHaz;

  // Reset dominates so the decode arms stay mutually exclusive.
  assign stallLive = rst_i && stall;
  assign takenBr   = IFID_Branch_i && BranchTaken_i;

  // Pipeline control: reset freeze, stall bubble, or run with flush.
  always_comb begin
    PCWrite_o   = 1'b1;
    IFIDWrite_o = 1'b1;
    Bubble_o    = 1'b0;
    IFIDFlush_o = 1'b0;
    unique case (1'b1)
      !rst_i: begin
        PCWrite_o   = 1'b0;
        IFIDWrite_o = 1'b0;
        Bubble_o    = 1'b1;
      end
      stallLive: begin
        PCWrite_o   = 1'b0;
        IFIDWrite_o = 1'b0;
        Bubble_o    = 1'b1;
      end
      default: begin
        IFIDFlush_o = takenBr;
      end
    endcase
  end

  // Stall-depth tracker; a third consecutive stall is illegal.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= RUN;
      StallErr_o <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (stall) state <= STALL1;
        end
        STALL1: begin
          state <= stall ? STALL2 : RUN;
        end
        STALL2: begin
          if (stall) StallErr_o <= 1'b1;
          else       state      <= RUN;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      StallCnt_o <= '0;
    end else if (stall && (StallCnt_o != CNT_MAX)) begin
      StallCnt_o <= StallCnt_o + CNT_ONE;
    end
  end

  // Saturating flush counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      FlushCnt_o <= '0;
    end else if (IFIDFlush_o && (FlushCnt_o != CNT_MAX)) begin
      FlushCnt_o <= FlushCnt_o + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus random traffic
// against a rule-level reference model.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  logic [4:0] rs1, rs2, idRd, exRd;
  logic u1, u2, br, tk, rw, mr, exMr;

  logic pcW, ifW, bub, fl, err;
  logic [15:0] sCnt, fCnt;
  logic pcW2, ifW2, bub2, fl2, err2;
  logic [1:0] sCnt2, fCnt2;

  int compared = 0;
  int mismatched = 0;

  int mStall, mFlush, mSat, mRun;
  bit mErr;

  always #5 clk_i = ~clk_i;

  hazard_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .IFID_Rs1_i(rs1), .IFID_Rs2_i(rs2),
    .IFID_UsesRs1_i(u1), .IFID_UsesRs2_i(u2),
    .IFID_Branch_i(br), .BranchTaken_i(tk),
    .IDEX_RegWrite_i(rw), .IDEX_MemRead_i(mr),
    .IDEX_Rd_i(idRd),
    .EXMEM_MemRead_i(exMr), .EXMEM_Rd_i(exRd),
    .PCWrite_o(pcW), .IFIDWrite_o(ifW),
    .Bubble_o(bub), .IFIDFlush_o(fl),
    .StallCnt_o(sCnt), .FlushCnt_o(fCnt),
    .StallErr_o(err)
  );

  hazard_ctrl #(.CNT_W(2)) dutSat (
    .clk_i(clk_i), .rst_i(rst_i),
    .IFID_Rs1_i(rs1), .IFID_Rs2_i(rs2),
    .IFID_UsesRs1_i(u1), .IFID_UsesRs2_i(u2),
    .IFID_Branch_i(br), .BranchTaken_i(tk),
    .IDEX_RegWrite_i(rw), .IDEX_MemRead_i(mr),
    .IDEX_Rd_i(idRd),
    .EXMEM_MemRead_i(exMr), .EXMEM_Rd_i(exRd),
    .PCWrite_o(pcW2), .IFIDWrite_o(ifW2),
    .Bubble_o(bub2), .IFIDFlush_o(fl2),
    .StallCnt_o(sCnt2), .FlushCnt_o(fCnt2),
    .StallErr_o(err2)
  );

  function automatic bit srcHit(int rd);
    return (rd != 0) &&
           ((u1 && int'(rs1) == rd) || (u2 && int'(rs2) == rd));
  endfunction

  function automatic bit expStall();
    bit lu, ba, bl;
    lu = mr && srcHit(int'(idRd));
    ba = br && rw && srcHit(int'(idRd));
    bl = br && exMr && srcHit(int'(exRd));
    return lu || ba || bl;
  endfunction

  function automatic bit expFlush();
    return rst_i && !expStall() && br && tk;
  endfunction

  // Reference model: counters, consecutive-stall run length, sticky error.
  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mStall <= 0; mFlush <= 0; mSat <= 0;
      mRun <= 0; mErr <= 1'b0;
    end else begin
      if (expStall()) begin
        mStall <= (mStall < 65535) ? mStall + 1 : mStall;
        mSat   <= (mSat < 3) ? mSat + 1 : mSat;
        mRun   <= (mRun < 3) ? mRun + 1 : mRun;
        if (mRun >= 2) mErr <= 1'b1;
      end else begin
        mRun <= 0;
      end
      if (expFlush())
        mFlush <= (mFlush < 65535) ? mFlush + 1 : mFlush;
    end
  end

  task automatic setIn(int a, int b, bit ua, bit ub, bit isBr,
                       bit taken, bit regW, bit memR, int dRd,
                       bit eMr, int eRd);
    rs1 = 5'(a); rs2 = 5'(b); u1 = ua; u2 = ub;
    br = isBr; tk = taken; rw = regW; mr = memR;
    idRd = 5'(dRd); exMr = eMr; exRd = 5'(eRd);
  endtask

  task automatic setIdle();
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    setIn(5, 0, 1, 0, 1, 1, 1, 1, 5, 1, 5);
    rst_i = 1'b0;
    #1;
    compared++;
    if ({pcW, ifW, bub, fl} !== 4'b0010) begin
      mismatched++;
      $display("FAIL reset_ctl: got %b want 0010", {pcW, ifW, bub, fl});
    end
    @(posedge clk_i); #1;
    compared++;
    if (sCnt !== 16'd0 || fCnt !== 16'd0 || err !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_regs: got s=%0d f=%0d e=%b want 0 0 0",
               sCnt, fCnt, err);
    end
    compared++;
    if (dut.state !== RUN) begin
      mismatched++;
      $display("FAIL reset_state: got %0d want RUN", dut.state);
    end
    @(negedge clk_i);
    setIdle();
    rst_i = 1'b1;
  endtask

  task automatic test_load_use();
    @(negedge clk_i);
    setIn(5, 1, 1, 1, 0, 0, 1, 1, 5, 0, 0);
    #1;
    compared++;
    if ({pcW, ifW, bub, fl} !== 4'b0010 || sCnt !== 16'd0) begin
      mismatched++;
      $display("FAIL lu_stall: got %b cnt=%0d want 0010 cnt=0",
               {pcW, ifW, bub, fl}, sCnt);
    end
    @(posedge clk_i); #1;
    compared++;
    if (sCnt !== 16'd1 || dut.state !== STALL1) begin
      mismatched++;
      $display("FAIL lu_count: got cnt=%0d st=%0d want 1 STALL1",
               sCnt, dut.state);
    end
    @(negedge clk_i);
    setIn(5, 1, 1, 1, 0, 0, 0, 0, 0, 1, 5);
    #1;
    compared++;
    if ({pcW, ifW, bub, fl} !== 4'b1100) begin
      mismatched++;
      $display("FAIL lu_release: got %b want 1100", {pcW, ifW, bub, fl});
    end
    @(posedge clk_i); #1;
    compared++;
    if (sCnt !== 16'd1 || dut.state !== RUN) begin
      mismatched++;
      $display("FAIL lu_after: got cnt=%0d st=%0d want 1 RUN",
               sCnt, dut.state);
    end
  endtask

  task automatic test_branch_load();
    int pre;
    pre = mStall;
    @(negedge clk_i);
    setIn(5, 0, 1, 1, 1, 0, 1, 1, 5, 0, 0);
    #1;
    compared++;
    if (pcW !== 1'b0 || bub !== 1'b1) begin
      mismatched++;
      $display("FAIL bl_stall1: got pc=%b bub=%b want 0 1", pcW, bub);
    end
    @(posedge clk_i); #1;
    compared++;
    if (dut.state !== STALL1) begin
      mismatched++;
      $display("FAIL bl_state1: got %0d want STALL1", dut.state);
    end
    @(negedge clk_i);
    setIn(5, 0, 1, 1, 1, 0, 0, 0, 0, 1, 5);
    #1;
    compared++;
    if (pcW !== 1'b0 || bub !== 1'b1 || fl !== 1'b0) begin
      mismatched++;
      $display("FAIL bl_stall2: got pc=%b bub=%b fl=%b want 0 1 0",
               pcW, bub, fl);
    end
    @(posedge clk_i); #1;
    compared++;
    if (dut.state !== STALL2 || err !== 1'b0) begin
      mismatched++;
      $display("FAIL bl_state2: got st=%0d err=%b want STALL2 0",
               dut.state, err);
    end
    @(negedge clk_i);
    setIn(5, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    #1;
    compared++;
    if (pcW !== 1'b1 || bub !== 1'b0) begin
      mismatched++;
      $display("FAIL bl_release: got pc=%b bub=%b want 1 0", pcW, bub);
    end
    @(posedge clk_i); #1;
    compared++;
    if (dut.state !== RUN || err !== 1'b0 || sCnt !== 16'(pre + 2)) begin
      mismatched++;
      $display("FAIL bl_end: got st=%0d err=%b cnt=%0d want RUN 0 %0d",
               dut.state, err, sCnt, pre + 2);
    end
  endtask

  task automatic test_flush();
    int pre;
    pre = mFlush;
    @(negedge clk_i);
    setIn(1, 2, 1, 1, 1, 1, 1, 1, 3, 1, 4);
    #1;
    compared++;
    if ({pcW, ifW, bub, fl} !== 4'b1101) begin
      mismatched++;
      $display("FAIL fl_taken: got %b want 1101", {pcW, ifW, bub, fl});
    end
    @(posedge clk_i); #1;
    compared++;
    if (fCnt !== 16'(pre + 1)) begin
      mismatched++;
      $display("FAIL fl_count: got %0d want %0d", fCnt, pre + 1);
    end
    @(negedge clk_i);
    setIn(1, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    #1;
    compared++;
    if (fl !== 1'b0) begin
      mismatched++;
      $display("FAIL fl_not_taken: got %b want 0", fl);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_branch_alu();
    int preF, preS;
    preF = mFlush;
    preS = mStall;
    @(negedge clk_i);
    setIn(0, 7, 0, 1, 1, 1, 1, 0, 7, 0, 0);
    #1;
    compared++;
    if ({pcW, ifW, bub, fl} !== 4'b0010) begin
      mismatched++;
      $display("FAIL ba_stall: got %b want 0010", {pcW, ifW, bub, fl});
    end
    @(posedge clk_i); #1;
    @(negedge clk_i);
    setIn(0, 7, 0, 1, 1, 1, 0, 0, 0, 0, 7);
    #1;
    compared++;
    if ({pcW, ifW, bub, fl} !== 4'b1101) begin
      mismatched++;
      $display("FAIL ba_flush: got %b want 1101", {pcW, ifW, bub, fl});
    end
    @(posedge clk_i); #1;
    compared++;
    if (fCnt !== 16'(preF + 1) || sCnt !== 16'(preS + 1)) begin
      mismatched++;
      $display("FAIL ba_counts: got f=%0d s=%0d want %0d %0d",
               fCnt, sCnt, preF + 1, preS + 1);
    end
  endtask

  task automatic test_reg0();
    @(negedge clk_i);
    setIn(0, 0, 1, 1, 1, 0, 1, 1, 0, 1, 0);
    #1;
    compared++;
    if ({pcW, ifW, bub, fl} !== 4'b1100) begin
      mismatched++;
      $display("FAIL reg0: got %b want 1100", {pcW, ifW, bub, fl});
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_stall_err();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      setIn(9, 0, 1, 0, 0, 0, 1, 1, 9, 0, 0);
      @(posedge clk_i); #1;
      compared++;
      if (err !== (i == 2)) begin
        mismatched++;
        $display("FAIL err_depth%0d: got %b want %b", i, err, i == 2);
      end
    end
    @(negedge clk_i);
    setIdle();
    @(posedge clk_i); #1;
    compared++;
    if (err !== 1'b1 || dut.state !== RUN) begin
      mismatched++;
      $display("FAIL err_sticky: got e=%b st=%0d want 1 RUN",
               err, dut.state);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    rst_i = 1'b1;
  endtask

  task automatic test_random();
    bit s, f;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_i);
      setIn($urandom_range(0, 3), $urandom_range(0, 3),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), $urandom_range(0, 3),
            1'($urandom), $urandom_range(0, 3));
      #1;
      s = expStall();
      f = expFlush();
      compared++;
      if ({pcW, ifW, bub, fl} !== {!s, !s, s, f}) begin
        mismatched++;
        $display("FAIL rnd_ctl[%0d]: got %b want %b", i,
                 {pcW, ifW, bub, fl}, {!s, !s, s, f});
      end
      @(posedge clk_i); #1;
      compared++;
      if (sCnt !== 16'(mStall) || fCnt !== 16'(mFlush) ||
          err !== mErr || sCnt2 !== 2'(mSat)) begin
        mismatched++;
        $display("FAIL rnd_regs[%0d]: got s=%0d f=%0d e=%b sat=%0d want %0d %0d %b %0d",
                 i, sCnt, fCnt, err, sCnt2, mStall, mFlush, mErr, mSat);
      end
    end
  endtask

  task automatic test_sat_reset();
    @(negedge clk_i);
    setIdle();
    rst_i = 1'b0;
    #1;
    rst_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      setIn(5, 1, 1, 1, 0, 0, 1, 1, 5, 0, 0);
      @(posedge clk_i);
      @(negedge clk_i);
      setIdle();
      @(posedge clk_i);
    end
    #1;
    compared++;
    if (sCnt2 !== 2'd3 || sCnt !== 16'd5) begin
      mismatched++;
      $display("FAIL sat_hold: got sat=%0d wide=%0d want 3 5",
               sCnt2, sCnt);
    end
    @(negedge clk_i);
    setIn(5, 1, 1, 1, 0, 0, 1, 1, 5, 0, 0);
    @(posedge clk_i);
    @(posedge clk_i); #1;
    compared++;
    if (dut.state !== STALL2) begin
      mismatched++;
      $display("FAIL mid_pre: got %0d want STALL2", dut.state);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    compared++;
    if ({pcW, ifW, bub, fl} !== 4'b0010 || dut.state !== RUN ||
        sCnt !== 16'd0 || sCnt2 !== 2'd0 || fCnt !== 16'd0 ||
        err !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_reset: got ctl=%b st=%0d s=%0d sat=%0d f=%0d e=%b",
               {pcW, ifW, bub, fl}, dut.state, sCnt, sCnt2, fCnt, err);
    end
    @(negedge clk_i);
    setIdle();
    rst_i = 1'b1;
  endtask

  initial begin
    setIdle();
    test_reset();
    test_load_use();
    test_branch_load();
    test_flush();
    test_branch_alu();
    test_reg0();
    test_stall_err();
    test_random();
    test_sat_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
